dmem_port_arbiter: RTL and testbench

- Shares the single-port 4096x32 dmem syncram between two requesters: the processor data port (cpu) and a host/loader port (host) used for test-image load and readback.
- Sits between the processor's dmem outputs, a host interface and the dmem instance, clocked by the dmem clock.
- Sequences each access through a small FSM, respects the syncram read latency, and round-robins between requesters when both are waiting.

---
 rtl/dmem_port_arbiter_pkg.sv | 19 +
 rtl/dmem_port_arbiter_if.sv | 38 +++
 rtl/dmem_port_arbiter_arb_rr2.sv | 20 ++
 rtl/dmem_port_arbiter.sv | 175 +++++++++++++++++
 tb/tb_dmem_port_arbiter.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types and constants for the dmem port arbiter.
// Used by the arbiter top, its round-robin picker and the requester interface.
package dmem_arb_pkg;

   localparam int unsigned DMEM_ADDR_W = 12;
   localparam int unsigned DMEM_DATA_W = 32;

   // Requester ids double as bit positions in the request vector.
   localparam logic REQ_CPU  = 1'b0;
   localparam logic REQ_HOST = 1'b1;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      WAIT,
      RESP
   } arb_state_e;

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// One requester's handshake to the dmem port arbiter.
// The requester drives the master side; the arbiter takes the slave side.
interface dmem_port_arbiter_if
   import dmem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W = DMEM_ADDR_W,
   parameter int unsigned DATA_W = DMEM_DATA_W
) ();

   logic              req;
   logic              wren;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] data;
   logic              gnt;
   logic [DATA_W-1:0] q;
   logic              valid;

   modport master (
      output req,
      output wren,
      output addr,
      output data,
      input  gnt,
      input  q,
      input  valid
   );

   modport slave (
      input  req,
      input  wren,
      input  addr,
      input  data,
      output gnt,
      output q,
      output valid
   );

endinterface

// File: rtl/dmem_port_arbiter_arb_rr2.sv
// Combinational two-way round-robin picker: on a tie the requester that
// did not win last time is chosen; otherwise the lone requester wins.
module arb_rr2
   import dmem_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last,
   output logic       winner
);

   always_comb begin
      winner = REQ_CPU;
      if (req[REQ_CPU] && req[REQ_HOST]) begin
         winner = ~last;
      end else if (req[REQ_HOST]) begin
         winner = REQ_HOST;
      end
   end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the single-port dmem syncram between the cpu and host requesters.
// Define DMEM_ARB_HOST_PRIORITY_EN to make the host win every tie.
module dmem_port_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W   = DMEM_ADDR_W,
   parameter int unsigned DATA_W   = DMEM_DATA_W,
   parameter int unsigned READ_LAT = 1
) (
   input  logic               clock,
   input  logic               reset,
   dmem_port_arbiter_if.slave cpu,
   dmem_port_arbiter_if.slave host,
   output logic [ADDR_W-1:0]  mem_address,
   output logic [DATA_W-1:0]  mem_data,
   output logic               mem_wren,
   input  logic [DATA_W-1:0]  mem_q,
   output logic               busy
);

   arb_state_e        state_q, state_d;
   logic [1:0]        lat_cnt_q, lat_cnt_d;
   logic              owner_q, owner_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              wren_q, wren_d;
   logic              cpu_gnt_q, cpu_gnt_d;
   logic              host_gnt_q, host_gnt_d;
   logic              cpu_valid_q, cpu_valid_d;
   logic              host_valid_q, host_valid_d;
   logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
   logic [DATA_W-1:0] host_rdata_q, host_rdata_d;

   logic [1:0]        req_vec;
   logic              last_in;
   logic              pick;

   assign req_vec = {host.req, cpu.req};

`ifdef DMEM_ARB_HOST_PRIORITY_EN
   // Pretending the cpu won last makes the picker hand every tie to the host.
   assign last_in = REQ_CPU;
`else
   logic last_q, last_d;
   assign last_in = last_q;
`endif

   arb_rr2 u_arb (
      .req    (req_vec),
      .last   (last_in),
      .winner (pick)
   );

   always_comb begin
      state_d      = state_q;
      lat_cnt_d    = lat_cnt_q;
      owner_d      = owner_q;
      addr_d       = addr_q;
      data_d       = data_q;
      wren_d       = 1'b0;
      cpu_gnt_d    = 1'b0;
      host_gnt_d   = 1'b0;
      cpu_valid_d  = 1'b0;
      host_valid_d = 1'b0;
      cpu_rdata_d  = cpu_rdata_q;
      host_rdata_d = host_rdata_q;
`ifndef DMEM_ARB_HOST_PRIORITY_EN
      last_d       = last_q;
`endif

      unique case (state_q)
         IDLE: begin
            if (|req_vec) begin
               owner_d = pick;
               state_d = ACCESS;
`ifndef DMEM_ARB_HOST_PRIORITY_EN
               last_d  = pick;
`endif
               if (pick == REQ_HOST) begin
                  addr_d     = host.addr;
                  data_d     = host.data;
                  wren_d     = host.wren;
                  host_gnt_d = 1'b1;
               end else begin
                  addr_d    = cpu.addr;
                  data_d    = cpu.data;
                  wren_d    = cpu.wren;
                  cpu_gnt_d = 1'b1;
               end
            end
         end

         ACCESS: begin
            if (wren_q) begin
               state_d = IDLE;
            end else if (READ_LAT <= 1) begin
               state_d = RESP;
            end else begin
               lat_cnt_d = 2'(READ_LAT - 1);
               state_d   = WAIT;
            end
         end

         // Leave once the count being decremented hits zero.
         WAIT: begin
            lat_cnt_d = lat_cnt_q - 2'd1;
            if (lat_cnt_q <= 2'd1) begin
               state_d = RESP;
            end
         end

         RESP: begin
            state_d = IDLE;
            if (owner_q == REQ_HOST) begin
               host_rdata_d = mem_q;
               host_valid_d = 1'b1;
            end else begin
               cpu_rdata_d = mem_q;
               cpu_valid_d = 1'b1;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= IDLE;
         lat_cnt_q    <= 2'd0;
         owner_q      <= REQ_CPU;
         addr_q       <= '0;
         data_q       <= '0;
         wren_q       <= 1'b0;
         cpu_gnt_q    <= 1'b0;
         host_gnt_q   <= 1'b0;
         cpu_valid_q  <= 1'b0;
         host_valid_q <= 1'b0;
         cpu_rdata_q  <= '0;
         host_rdata_q <= '0;
`ifndef DMEM_ARB_HOST_PRIORITY_EN
         last_q       <= REQ_HOST;
`endif
      end else begin
         state_q      <= state_d;
         lat_cnt_q    <= lat_cnt_d;
         owner_q      <= owner_d;
         addr_q       <= addr_d;
         data_q       <= data_d;
         wren_q       <= wren_d;
         cpu_gnt_q    <= cpu_gnt_d;
         host_gnt_q   <= host_gnt_d;
         cpu_valid_q  <= cpu_valid_d;
         host_valid_q <= host_valid_d;
         cpu_rdata_q  <= cpu_rdata_d;
         host_rdata_q <= host_rdata_d;
`ifndef DMEM_ARB_HOST_PRIORITY_EN
         last_q       <= last_d;
`endif
      end
   end

   assign mem_address = addr_q;
   assign mem_data    = data_q;
   assign mem_wren    = wren_q;
   assign busy        = (state_q != IDLE);

   assign cpu.gnt    = cpu_gnt_q;
   assign cpu.valid  = cpu_valid_q;
   assign cpu.q      = cpu_rdata_q;
   assign host.gnt   = host_gnt_q;
   assign host.valid = host_valid_q;
   assign host.q     = host_rdata_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter: one instance with a 1-clock syncram
// and one with a 3-clock syncram, each backed by a behavioural memory.
module tb_dmem_port_arbiter;
   import dmem_arb_pkg::*;

   localparam int unsigned AW = 12;
   localparam int unsigned DW = 32;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst1, rst3;
   logic [AW-1:0] mem_address1, mem_address3;
   logic [DW-1:0] mem_data1, mem_data3;
   logic          mem_wren1, mem_wren3;
   logic [DW-1:0] mem_q1, mem_q3;
   logic          busy1, busy3;

   dmem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) cpu1 ();
   dmem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) host1 ();
   dmem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) cpu3 ();
   dmem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) host3 ();

   dmem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(1)) u_dut1 (
      .clock       (clk),
      .reset       (rst1),
      .cpu         (cpu1),
      .host        (host1),
      .mem_address (mem_address1),
      .mem_data    (mem_data1),
      .mem_wren    (mem_wren1),
      .mem_q       (mem_q1),
      .busy        (busy1)
   );

   dmem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(3)) u_dut3 (
      .clock       (clk),
      .reset       (rst3),
      .cpu         (cpu3),
      .host        (host3),
      .mem_address (mem_address3),
      .mem_data    (mem_data3),
      .mem_wren    (mem_wren3),
      .mem_q       (mem_q3),
      .busy        (busy3)
   );

   function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
      return 32'hC0DE_0000 | {{(DW-AW){1'b0}}, a};
   endfunction

   // Behavioural syncrams, refilled with a known pattern while in reset.
   logic [DW-1:0] mem1 [0:4095];
   logic [DW-1:0] mem3 [0:4095];
   logic [DW-1:0] q3_p0, q3_p1;

   always @(posedge clk) begin
      if (rst1) begin
         for (int i = 0; i < 4096; i++) mem1[i] <= init_word(AW'(i));
      end else if (mem_wren1) begin
         mem1[mem_address1] <= mem_data1;
      end
      mem_q1 <= mem1[mem_address1];
   end

   always @(posedge clk) begin
      if (rst3) begin
         for (int i = 0; i < 4096; i++) mem3[i] <= init_word(AW'(i));
      end else if (mem_wren3) begin
         mem3[mem_address3] <= mem_data3;
      end
      q3_p0  <= mem3[mem_address3];
      q3_p1  <= q3_p0;
      mem_q3 <= q3_p1;
   end

   int n_vec = 0;
   int n_bad = 0;

   task automatic check_val(input string tag, input logic [DW-1:0] got,
                            input logic [DW-1:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic order     [0:4];
   logic exp_order [0:4];
   int   n_gnt, n_val;
   logic saw_a, saw_b;
   logic [DW-1:0] rd;

   initial begin
      rst1 = 1'b1;
      rst3 = 1'b1;
      cpu1.req = 1'b0;  cpu1.wren = 1'b0;  cpu1.addr = '0;  cpu1.data = '0;
      host1.req = 1'b0; host1.wren = 1'b0; host1.addr = '0; host1.data = '0;
      cpu3.req = 1'b0;  cpu3.wren = 1'b0;  cpu3.addr = '0;  cpu3.data = '0;
      host3.req = 1'b0; host3.wren = 1'b0; host3.addr = '0; host3.data = '0;
      repeat (3) tick();

      // Reset state
      check_val("rst_busy",     32'(busy1),       32'd0);
      check_val("rst_mem_wren", 32'(mem_wren1),   32'd0);
      check_val("rst_mem_addr", 32'(mem_address1), 32'd0);
      check_val("rst_mem_data", mem_data1,        32'd0);
      check_val("rst_cpu_gnt",  32'(cpu1.gnt),    32'd0);
      check_val("rst_host_gnt", 32'(host1.gnt),   32'd0);
      check_val("rst_cpu_vld",  32'(cpu1.valid),  32'd0);
      check_val("rst_host_vld", 32'(host1.valid), 32'd0);
      check_val("rst_cpu_q",    cpu1.q,           32'd0);
      check_val("rst_host_q",   host1.q,          32'd0);
      rst1 = 1'b0;
      rst3 = 1'b0;

      // Single cpu write
      cpu1.req = 1'b1; cpu1.wren = 1'b1; cpu1.addr = 12'h010; cpu1.data = 32'hDEAD_BEEF;
      tick();
      check_val("wr_gnt",      32'(cpu1.gnt),     32'd1);
      check_val("wr_host_gnt", 32'(host1.gnt),    32'd0);
      check_val("wr_wren",     32'(mem_wren1),    32'd1);
      check_val("wr_addr",     32'(mem_address1), 32'h010);
      check_val("wr_data",     mem_data1,         32'hDEAD_BEEF);
      check_val("wr_busy",     32'(busy1),        32'd1);
      cpu1.req = 1'b0; cpu1.wren = 1'b0;
      tick();
      check_val("wr_gnt_drop",  32'(cpu1.gnt),     32'd0);
      check_val("wr_wren_drop", 32'(mem_wren1),    32'd0);
      check_val("wr_idle",      32'(busy1),        32'd0);
      check_val("wr_addr_hold", 32'(mem_address1), 32'h010);
      check_val("wr_no_vld0",   32'(cpu1.valid),   32'd0);
      tick();
      check_val("wr_no_vld1",   32'(cpu1.valid),   32'd0);
      check_val("wr_landed",    mem1[12'h010],     32'hDEAD_BEEF);

      // Single cpu read of the word just written
      cpu1.req = 1'b1; cpu1.addr = 12'h010;
      tick();
      check_val("rd_gnt",  32'(cpu1.gnt),  32'd1);
      check_val("rd_wren", 32'(mem_wren1), 32'd0);
      cpu1.req = 1'b0;
      tick();
      check_val("rd_vld_early", 32'(cpu1.valid), 32'd0);
      tick();
      check_val("rd_vld",      32'(cpu1.valid),  32'd1);
      check_val("rd_q",        cpu1.q,           32'hDEAD_BEEF);
      check_val("rd_host_vld", 32'(host1.valid), 32'd0);
      tick();
      check_val("rd_vld_pulse", 32'(cpu1.valid), 32'd0);
      check_val("rd_q_hold",    cpu1.q,          32'hDEAD_BEEF);

      // Host request raised and withdrawn while the cpu owns the bus
      cpu1.req = 1'b1; cpu1.addr = 12'h050;
      tick();
      check_val("wd_cpu_gnt", 32'(cpu1.gnt), 32'd1);
      cpu1.req = 1'b0;
      host1.req = 1'b1; host1.wren = 1'b1; host1.addr = 12'h060; host1.data = 32'hBAD0_BAD0;
      tick();
      host1.req = 1'b0; host1.wren = 1'b0;
      saw_a = 1'b0; saw_b = 1'b0; rd = '0;
      repeat (5) begin
         tick();
         saw_a = saw_a | host1.gnt;
         saw_b = saw_b | mem_wren1;
         if (cpu1.valid) rd = cpu1.q;
      end
      check_val("wd_host_gnt", 32'(saw_a),     32'd0);
      check_val("wd_wren",     32'(saw_b),     32'd0);
      check_val("wd_cpu_q",    rd,             init_word(12'h050));
      check_val("wd_mem_kept", mem1[12'h060],  init_word(12'h060));

      // Both requesters hold reads from reset
      rst1 = 1'b1;
      cpu1.req = 1'b1;  cpu1.wren = 1'b0;  cpu1.addr = 12'h020;
      host1.req = 1'b1; host1.wren = 1'b0; host1.addr = 12'h030;
      repeat (2) tick();
      rst1 = 1'b0;
`ifdef DMEM_ARB_HOST_PRIORITY_EN
      exp_order[0] = 1'b1; exp_order[1] = 1'b1; exp_order[2] = 1'b1;
      exp_order[3] = 1'b1; exp_order[4] = 1'b0;
`else
      exp_order[0] = 1'b0; exp_order[1] = 1'b1; exp_order[2] = 1'b0;
      exp_order[3] = 1'b1; exp_order[4] = 1'b0;
`endif
      for (int k = 0; k < 5; k++) order[k] = 1'b0;
      n_gnt = 0;
      n_val = 0;
      for (int cyc = 0; cyc < 24; cyc++) begin
         tick();
         check_val("tie_excl", 32'(cpu1.gnt & host1.gnt), 32'd0);
         if (cpu1.gnt || host1.gnt) begin
            if (n_gnt < 5) order[n_gnt] = host1.gnt;
            n_gnt++;
            if (n_gnt == 4) host1.req = 1'b0;
            if (n_gnt == 5) cpu1.req = 1'b0;
         end
         if (cpu1.valid) begin
            check_val("tie_cpu_q", cpu1.q, init_word(12'h020));
            n_val++;
         end
         if (host1.valid) begin
            check_val("tie_host_q", host1.q, init_word(12'h030));
            n_val++;
         end
      end
      check_val("tie_grants", 32'(n_gnt), 32'd5);
      check_val("tie_valids", 32'(n_val), 32'd5);
      for (int k = 0; k < 5; k++) begin
         check_val($sformatf("tie_order%0d", k), 32'(order[k]), 32'(exp_order[k]));
      end
      check_val("tie_host_q_hold", host1.q, init_word(12'h030));

      // Reset asserted while a 3-clock read is waiting
      cpu3.req = 1'b1; cpu3.wren = 1'b0; cpu3.addr = 12'h070;
      tick();
      check_val("mr_gnt", 32'(cpu3.gnt), 32'd1);
      cpu3.req = 1'b0;
      tick();
      check_val("mr_busy_wait", 32'(busy3), 32'd1);
      rst3 = 1'b1;
      tick();
      check_val("mr_busy_rst", 32'(busy3),      32'd0);
      check_val("mr_wren_rst", 32'(mem_wren3),  32'd0);
      check_val("mr_vld_rst",  32'(cpu3.valid), 32'd0);
      check_val("mr_gnt_rst",  32'(cpu3.gnt),   32'd0);
      rst3 = 1'b0;
      saw_a = 1'b0;
      repeat (6) begin
         tick();
         saw_a = saw_a | cpu3.valid;
      end
      check_val("mr_no_vld", 32'(saw_a), 32'd0);

      // Following read is served with the full 3-clock latency
      cpu3.req = 1'b1; cpu3.addr = 12'h071;
      tick();
      check_val("lat3_gnt", 32'(cpu3.gnt), 32'd1);
      cpu3.req = 1'b0;
      saw_a = 1'b0;
      repeat (3) begin
         tick();
         saw_a = saw_a | cpu3.valid;
      end
      check_val("lat3_early", 32'(saw_a), 32'd0);
      tick();
      check_val("lat3_vld", 32'(cpu3.valid), 32'd1);
      check_val("lat3_q",   cpu3.q,          init_word(12'h071));
      tick();
      check_val("lat3_idle", 32'(busy3), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
